// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: imem read port plus the decode-facing handshake.
// A head word transfers on a rising edge where valid_out & ready_in are both high;
// valid_out, inst_out and pc_out stay stable while valid_out is high and ready_in is low.
interface inst_fetch_if #(
   parameter int DATAPATH_WIDTH  = 64,
   parameter int INST_WIDTH      = 32,
   parameter int INST_ADDR_WIDTH = 9
);
   logic                       imem_rd_en;
   logic [INST_ADDR_WIDTH-1:0] imem_addr;
   logic [INST_WIDTH-1:0]      imem_data_in;
   logic [DATAPATH_WIDTH-1:0]  inst_out;
   logic [INST_ADDR_WIDTH-1:0] pc_out;
   logic                       valid_out;
   logic                       ready_in;

   modport master (
      output imem_rd_en, imem_addr, inst_out, pc_out, valid_out,
      input  imem_data_in, ready_in
   );

   modport slave (
      input  imem_rd_en, imem_addr, inst_out, pc_out, valid_out,
      output imem_data_in, ready_in
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, 1-cycle imem requests, credit-limited fetch FIFO, branch flush.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_out / stall_cnt_out counters.
module inst_fetch #(
   parameter int DATAPATH_WIDTH  = 64,
   parameter int INST_WIDTH      = 32,
   parameter int INST_ADDR_WIDTH = 9,
   parameter int BUF_DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       run_in,
   input  logic                       branch_en_in,
   input  logic [INST_ADDR_WIDTH-1:0] branch_addr_in,
   inst_fetch_if.master               bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                fetch_cnt_out,
   output logic [31:0]                stall_cnt_out
`endif
);
   localparam int CW = $clog2(BUF_DEPTH);
   localparam int AW = INST_ADDR_WIDTH;

   logic [AW-1:0]         pc_q, pc_d;
   logic                  inflight_q, inflight_d;
   logic [AW-1:0]         inflight_pc_q, inflight_pc_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW:0]           count_q, count_d;
   logic [INST_WIDTH-1:0] buf_inst_q [BUF_DEPTH];
   logic [AW-1:0]         buf_pc_q   [BUF_DEPTH];

   logic          valid;
   logic          pop;
   logic          push;
   logic          issue;
   logic [CW+1:0] credit_used;

   assign valid = (count_q != '0);
   assign pop   = valid & bus.ready_in;
   // A returning word lands in the same cycle a branch flushes; it belongs to the old stream.
   assign push  = inflight_q & ~branch_en_in;

   // Counting the inflight word as occupied guarantees its slot exists when it returns.
   assign credit_used = {1'b0, count_q} + (CW+2)'(inflight_q) - (CW+2)'(pop);
   assign issue = reset_n & run_in & ~branch_en_in & (credit_used < (CW+2)'(BUF_DEPTH));

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (branch_en_in) begin
         pc_d = branch_addr_in;
      end else if (issue) begin
         pc_d          = pc_q + AW'(1);
         inflight_pc_d = pc_q;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + CW'(pop);
      wr_ptr_d = wr_ptr_q + CW'(push);
      count_d  = count_q + (CW+1)'(push) - (CW+1)'(pop);
      if (branch_en_in) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_inst_q[wr_ptr_q] <= bus.imem_data_in;
         buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
   end

   assign bus.imem_rd_en = issue;
   assign bus.imem_addr  = pc_q;
   assign bus.valid_out  = valid;
   // Outputs are forced to zero when empty so reset and flush present a clean head.
   assign bus.inst_out   = valid ? {{(DATAPATH_WIDTH-INST_WIDTH){1'b0}}, buf_inst_q[rd_ptr_q]}
                                 : '0;
   assign bus.pc_out     = valid ? buf_pc_q[rd_ptr_q] : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_q + 32'(pop);
         stall_cnt_q <= stall_cnt_q + 32'(valid & ~bus.ready_in);
      end
   end

   assign fetch_cnt_out = fetch_cnt_q;
   assign stall_cnt_out = stall_cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized run/ready/branch/reset traffic,
// checked against a word-counting stream model of the fetch stage.
module tb_inst_fetch;
   localparam int AW    = 9;
   localparam int IW    = 32;
   localparam int DW    = 64;
   localparam int DEPTH = 2;
   localparam int NPC   = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          ready = 1'b0;
   logic          br_en = 1'b0;
   logic [AW-1:0] br_addr = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   fetch_cnt, stall_cnt;
   int            fetch_exp = 0;
   int            stall_exp = 0;
`endif

   inst_fetch_if #(.DATAPATH_WIDTH(DW), .INST_WIDTH(IW), .INST_ADDR_WIDTH(AW)) bus ();

   inst_fetch #(
      .DATAPATH_WIDTH(DW), .INST_WIDTH(IW), .INST_ADDR_WIDTH(AW), .BUF_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset_n(rst_n),
      .run_in(run),
      .branch_en_in(br_en),
      .branch_addr_in(br_addr),
      .bus(bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_out(fetch_cnt),
      .stall_cnt_out(stall_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // synchronous instruction memory, 1-cycle latency
   logic [IW-1:0] imem [NPC];
   logic [IW-1:0] imem_q = '0;
   always @(posedge clk) if (bus.imem_rd_en) imem_q <= imem[bus.imem_addr];
   assign bus.imem_data_in = imem_q;
   assign bus.ready_in     = ready;

   // scoreboard
   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // reference model: next PC decode should receive, next PC to be fetched,
   // and words issued but not yet handed to decode
   int            exp_pc = 0;
   int            fetch_pc = 0;
   int            outstanding = 0;
   bit            hold_prev = 0;
   logic [AW-1:0] prev_pc;
   logic [DW-1:0] prev_inst;
   int            pop_i;
   bit            exp_issue;
   logic [DW-1:0] exp_q[$];

   task automatic model_reset();
      exp_pc = 0;
      fetch_pc = 0;
      outstanding = 0;
      hold_prev = 0;
`ifdef FETCH_PERF_CNT_EN
      fetch_exp = 0;
      stall_exp = 0;
`endif
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         pop_i = (bus.valid_out && ready) ? 1 : 0;
         exp_issue = run && !br_en && (outstanding - pop_i < DEPTH);
         check_eq("issue", bus.imem_rd_en, exp_issue);
         if (bus.imem_rd_en) check_eq("imem_addr", bus.imem_addr, fetch_pc);
         if (hold_prev) begin
            check_eq("hold_valid", bus.valid_out, 1);
            check_eq("hold_pc", bus.pc_out, prev_pc);
            check_eq("hold_inst", bus.inst_out, prev_inst);
         end
         if (pop_i != 0) begin
            exp_q.push_back({32'b0, imem[exp_pc]});
            check_eq("pop_pc", bus.pc_out, exp_pc);
            check_eq("pop_inst", bus.inst_out, exp_q.pop_front());
            exp_pc = (exp_pc + 1) % NPC;
         end
`ifdef FETCH_PERF_CNT_EN
         if (pop_i != 0) fetch_exp++;
         if (bus.valid_out && !ready) stall_exp++;
`endif
         hold_prev = bus.valid_out && !ready && !br_en;
         prev_pc   = bus.pc_out;
         prev_inst = bus.inst_out;
         if (br_en) begin
            exp_pc = br_addr;
            fetch_pc = br_addr;
            outstanding = 0;
         end else begin
            outstanding = outstanding + (bus.imem_rd_en ? 1 : 0) - pop_i;
            if (bus.imem_rd_en) fetch_pc = (fetch_pc + 1) % NPC;
         end
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, bus.valid_out, 0);
      check_eq({tag, "_pc"}, bus.pc_out, 0);
      check_eq({tag, "_inst"}, bus.inst_out, 0);
      check_eq({tag, "_rd_en"}, bus.imem_rd_en, 0);
`ifdef FETCH_PERF_CNT_EN
      check_eq({tag, "_fetch_cnt"}, fetch_cnt, 0);
      check_eq({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int got[$];
   int t5_exp[4] = '{'h1FE, 'h1FF, 'h000, 'h001};
   bit seen;

   initial begin
      for (int k = 0; k < NPC; k++) imem[k] = {16'($urandom_range(0, 65535)), 16'(k + 'h100)};

      // 1: reset, then streaming from PC 0
      run = 1'b1;
      ready = 1'b1;
      cyc(2);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t1_c0_rd_en", bus.imem_rd_en, 1);
      check_eq("t1_c0_addr", bus.imem_addr, 0);
      @(negedge clk);
      check_eq("t1_c1_valid", bus.valid_out, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("t1_valid", bus.valid_out, 1);
         check_eq("t1_pc", bus.pc_out, i);
         check_eq("t1_inst_lo", bus.inst_out[15:0], 'h100 + i);
      end

      // 2: backpressure for 5 cycles, then release
      cyc(1);
      ready = 1'b0;
      cyc(4);
      @(negedge clk);
      check_eq("t2_no_issue", bus.imem_rd_en, 0);
      check_eq("t2_valid", bus.valid_out, 1);
      cyc(1);
      ready = 1'b1;
      cyc(6);

      // 3: branch to 0x40 with a full FIFO
      ready = 1'b0;
      cyc(3);
      br_addr = 'h40;
      br_en = 1'b1;
      cyc(1);
      br_en = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      check_eq("t3_target_issue", bus.imem_rd_en, 1);
      check_eq("t3_target_addr", bus.imem_addr, 'h40);
      check_eq("t3_flushed", bus.valid_out, 0);
      @(negedge clk);
      check_eq("t3_wait", bus.valid_out, 0);
      @(negedge clk);
      check_eq("t3_valid", bus.valid_out, 1);
      check_eq("t3_pc", bus.pc_out, 'h40);

      // 4: branch in the same cycle as a pop
      cyc(4);
      br_addr = 'h80;
      br_en = 1'b1;
      @(negedge clk);
      check_eq("t4_pop_with_branch", bus.valid_out, 1);
      cyc(1);
      br_en = 1'b0;
      cyc(6);

      // 5: PC wrap from 0x1FE
      br_addr = 'h1FE;
      br_en = 1'b1;
      cyc(1);
      br_en = 1'b0;
      got.delete();
      for (int n = 0; n < 20 && got.size() < 4; n++) begin
         @(negedge clk);
         if (bus.valid_out) got.push_back(int'(bus.pc_out));
      end
      check_eq("t5_count", got.size(), 4);
      for (int i = 0; i < got.size(); i++) check_eq("t5_pc", got[i], t5_exp[i]);

      // 6: reset mid-stream with a request in flight
      cyc(1);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = bus.imem_rd_en;
      end
      check_eq("t6_saw_issue", seen, 1);
      @(posedge clk);
      #2;
      mid_reset();
      @(negedge clk);
      check_eq("t6_restart_addr", bus.imem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      check_eq("t6_restart_valid", bus.valid_out, 1);
      check_eq("t6_restart_pc", bus.pc_out, 0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         cyc(1);
         run     = ($urandom_range(0, 9) != 0);
         ready   = ($urandom_range(0, 9) < 7);
         br_en   = ($urandom_range(0, 19) == 0);
         br_addr = AW'($urandom_range(0, NPC - 1));
         if ($urandom_range(0, 599) == 0) begin
            br_en = 1'b0;
            mid_reset();
         end
      end

      // drain
      cyc(1);
      run = 1'b0;
      ready = 1'b1;
      br_en = 1'b0;
      cyc(6);
      @(negedge clk);
      check_eq("drain_empty", bus.valid_out, 0);
`ifdef FETCH_PERF_CNT_EN
      check_eq("fetch_cnt", fetch_cnt, 32'(fetch_exp));
      check_eq("stall_cnt", stall_cnt, 32'(stall_exp));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
